// File: rtl/hamming_top.sv
// rtl/hamming_top.sv - Hamming(7,4) single-error corrector with multiplexed seven-segment display
module hamming_top #(
    parameter int TOGGLE_CYCLES = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i,
    input  logic [6:0] e,
    output logic [6:0] d,
    output logic [3:0] c,
    output logic       x,
    output logic       y
);

    localparam int CW = (TOGGLE_CYCLES > 2) ? $clog2(TOGGLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TOGGLE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [3:0]    i_q;
    logic [6:0]    e_q;
    logic [3:0]    c_q, c_d;
    logic          x_q, x_d;
    logic          y_q, y_d;
    logic [2:0]    s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [6:0]    d_q, d_d;
    logic [6:0]    flip;
    logic [6:0]    corr;

    // e_q[k-1] holds Hamming position k; the syndrome directly names the bad position.
    always_comb begin
        s_d[0] = e_q[0] ^ e_q[2] ^ e_q[4] ^ e_q[6];
        s_d[1] = e_q[1] ^ e_q[2] ^ e_q[5] ^ e_q[6];
        s_d[2] = e_q[3] ^ e_q[4] ^ e_q[5] ^ e_q[6];
        flip = '0;
        if (s_d != 3'd0) begin
            flip[s_d - 3'd1] = 1'b1;
        end
        corr = e_q ^ flip;
        c_d  = {corr[6], corr[5], corr[4], corr[2]};
        x_d  = (s_d != 3'd0);
        y_d  = (c_d == i_q);
    end

    // Free-running display phase, independent of input traffic.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
        d_d = phase_q ? hex7({1'b0, s_q}) : hex7(c_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q     <= '0;
            e_q     <= '0;
            c_q     <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            s_q     <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            d_q     <= SEG_BLANK;
        end else begin
            i_q     <= i;
            e_q     <= e;
            c_q     <= c_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            d_q     <= d_d;
        end
    end

    assign d = d_q;
    assign c = c_q;
    assign x = x_q;
    assign y = y_q;

endmodule

// File: tb/tb_hamming_top.sv
// tb/tb_hamming_top.sv - scoreboard bench for hamming_top using directed vectors
module tb_hamming_top;

    localparam int T    = 4;
    localparam int HOLD = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i;
    logic [6:0] e;
    logic [6:0] d;
    logic [3:0] c;
    logic       x;
    logic       y;

    hamming_top #(.TOGGLE_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .i(i), .e(e),
        .d(d), .c(c), .x(x), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [3:0] c;
        logic       x;
        logic       y;
        logic [6:0] d;
        bit         chk_cxy;
        bit         chk_d;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   rst_edge = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done = 0;

    always @(posedge clk) edge_n++;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Display phase used to build d at edge m: phase after edge m-1.
    function automatic int phase_at(input int m);
        return ((m - 1 - rst_edge) / T) % 2;
    endfunction

    // Monitor: compare scoreboard entries at the falling edge after their due edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
            exp_t r;
            r = exp_q.pop_front();
            if (r.edge_no < edge_n) begin
                checks++;
                errors++;
                $display("FAIL missed_entry edge=%0d now=%0d", r.edge_no, edge_n);
            end else begin
                if (r.chk_cxy) begin
                    checks++;
                    if (c !== r.c) begin
                        errors++;
                        $display("FAIL c edge=%0d actual=%b required=%b", edge_n, c, r.c);
                    end
                    checks++;
                    if (x !== r.x) begin
                        errors++;
                        $display("FAIL x edge=%0d actual=%b required=%b", edge_n, x, r.x);
                    end
                    checks++;
                    if (y !== r.y) begin
                        errors++;
                        $display("FAIL y edge=%0d actual=%b required=%b", edge_n, y, r.y);
                    end
                end
                if (r.chk_d) begin
                    checks++;
                    if (d !== r.d) begin
                        errors++;
                        $display("FAIL d edge=%0d actual=%b required=%b", edge_n, d, r.d);
                    end
                end
            end
        end
    end

    task automatic push_reset(input int m);
        exp_t r;
        r.edge_no = m; r.c = 4'h0; r.x = 1'b0; r.y = 1'b0; r.d = 7'b1111111;
        r.chk_cxy = 1; r.chk_d = 1;
        exp_q.push_back(r);
    endtask

    // Hold the current inputs; push expectations starting at edge first_cxy.
    task automatic expect_hold(input int first_cxy, input int last,
                               input logic [3:0] ec, input logic ex, input logic ey,
                               input logic [2:0] es);
        for (int m = first_cxy; m <= last; m++) begin
            exp_t r;
            r.edge_no = m; r.c = ec; r.x = ex; r.y = ey;
            r.chk_cxy = 1;
            r.chk_d = (m >= first_cxy + 1);
            r.d = (phase_at(m) == 1) ? seg({1'b0, es}) : seg(ec);
            exp_q.push_back(r);
        end
    endtask

    task automatic apply(input logic [3:0] vi, input logic [6:0] ve,
                         input logic [3:0] ec, input logic ex, input logic ey,
                         input logic [2:0] es);
        int n;
        @(negedge clk);
        i = vi;
        e = ve;
        n = edge_n;
        expect_hold(n + 2, n + HOLD, ec, ex, ey, es);
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        i = '0;
        e = '0;
        @(negedge clk);
        push_reset(edge_n + 1);
        push_reset(edge_n + 2);
        repeat (2) @(negedge clk);
        rst_edge = edge_n;
        rst = 1'b0;

        //     i        e           c        x     y     S
        apply(4'b0101, 7'b0101101, 4'b0101, 1'b0, 1'b1, 3'd0);
        apply(4'b0101, 7'b0001101, 4'b0101, 1'b1, 1'b1, 3'd6);
        apply(4'b0101, 7'b0101100, 4'b0101, 1'b1, 1'b1, 3'd1);
        apply(4'b0011, 7'b0101101, 4'b0101, 1'b0, 1'b0, 3'd0);
        apply(4'b0101, 7'b0011101, 4'b0010, 1'b1, 1'b0, 3'd3);
        apply(4'b1111, 7'b1111111, 4'b1111, 1'b0, 1'b1, 3'd0);
        apply(4'b0000, 7'b1000000, 4'b0000, 1'b1, 1'b1, 3'd7);
        apply(4'b0000, 7'b0001000, 4'b0000, 1'b1, 1'b1, 3'd4);

        // Mid-run reset while the display shows the syndrome.
        apply(4'b0101, 7'b0001101, 4'b0101, 1'b1, 1'b1, 3'd6);
        for (int k = 0; k < 2 * T && ((edge_n - rst_edge) / T) % 2 != 1; k++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        push_reset(edge_n + 1);
        @(negedge clk);
        rst_edge = edge_n;
        rst = 1'b0;
        expect_hold(edge_n + 2, edge_n + HOLD, 4'b0101, 1'b1, 1'b1, 3'd6);
        repeat (HOLD) @(negedge clk);

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_top.md
Name: hamming_top

Overview:
- Board-level top of a Hamming(7,4) demonstrator running on a 27 MHz clock.
- Takes a 4-bit reference word `i` and a 7-bit received codeword `e`.
- Computes the syndrome, corrects any single-bit error and outputs the corrected 4-bit data word.
- Drives one active-low seven-segment display that alternates between the corrected data value and the syndrome (error position), plus two status flags.

Parameters:
- TOGGLE_CYCLES, 27000, clock cycles per display phase (1 ms at 27 MHz); must be at least 2.

Ports:
- clk  input  1  system clock, 27 MHz, rising-edge.
- rst  input  1  synchronous, active-high reset.
- i  input  4  reference data word (switches); i[0]=d1 … i[3]=d4.
- e  input  7  received codeword; e[k-1] is Hamming position k. Positions 1, 2, 4 are parity p1, p2, p3. Positions 3, 5, 6, 7 are data d1, d2, d3, d4.
- d  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- c  output  4  corrected data word {d4,d3,d2,d1}.
- x  output  1  error flag: 1 when the syndrome is non-zero.
- y  output  1  match flag: 1 when c equals the registered i.

Behaviour:
- All state updates on the rising edge of clk. rst is sampled only on the rising edge (synchronous, active-high) and overrides everything else.
- Reset values:
  - c=0, x=0, y=0, d=7'b1111111 (blank).
  - Input registers = 0, syndrome register = 0.
  - Phase = 0, phase counter = 0.
- Stage 1: register i and e (i_q, e_q) every cycle.
- Stage 2: from e_q, compute
  - s1 = XOR of positions 1, 3, 5, 7
  - s2 = XOR of positions 2, 3, 6, 7
  - s3 = XOR of positions 4, 5, 6, 7
  - syndrome S = {s3,s2,s1}, range 0..7
- Stage 2 correction:
  - If S≠0, invert position S of e_q; otherwise use e_q unchanged.
  - Register c = corrected {pos7,pos6,pos5,pos3}, x = (S≠0), y = (corrected data == i_q), and S.
  - Latency from i/e to c, x, y: 2 cycles.
- Two or more bit errors are not detected. The block still applies the single-error correction at position S (deterministic miscorrection); x=1.
- Display phase counter:
  - Counts 0..TOGGLE_CYCLES-1 and wraps to 0.
  - On the wrap cycle, phase toggles.
  - Counter and phase run independently of input activity.
- Display register, updated every cycle:
  - phase=0: d = hex segment code of c.
  - phase=1: d = hex segment code of {1'b0,S}.
  - Latency from c/S to d: 1 cycle, i.e. 3 cycles from input.
- Hex codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-operation: all outputs return to reset values on that edge. After release, valid c/x/y appear 2 cycles later and d 3 cycles later; the display starts in phase 0 with the counter at 0.
- Input changes are not debounced; each is reflected after the stated pipeline latency.

Test Plan:
- Reset then no-error input: rst high 2 cycles, then i=0101, e=0101101 → cycle 2: c=0101, x=0, y=1; cycle 3: d=0010010 ('5'); after TOGGLE_CYCLES, d=1000000 ('0', S=0).
- Single data error (position 6): i=0101, e=0001101 → c=0101, x=1, y=1. Phase 0: d=0010010. Phase 1: d=0000010 ('6').
- Single parity error (position 1): i=0101, e=0101100 → c=0101, x=1, y=1; phase 1 shows '1' (1111001).
- Mismatch: i=0011, e=0101101 → c=0101, x=0, y=0.
- Double error (positions 5 and 6): i=0101, e=0011101 → S=3, c=0010, x=1, y=0; phase 1 shows '3' (0110000).
- Reset mid-run: with TOGGLE_CYCLES=4, assert rst during phase 1 → next edge d=1111111, c=0, x=0, y=0; after release, phase 0 resumes and phase toggles every 4 cycles.
